// File: rtl/reg_slice_skid.sv
// rtl/reg_slice_skid.sv - two-entry valid/ready skid register slice with registered o_ready
// Optional upstream protocol checker on o_err is built when REG_SLICE_CHK_EN is defined.
module reg_slice_skid #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_err
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] main_q, main_d;
   logic [DATA_WIDTH-1:0] skid_q, skid_d;
   logic                  ready_q;
   logic                  push, pop;

   assign push    = i_valid & ready_q;
   assign pop     = (state_q != ST_EMPTY) & i_ready;
   assign o_ready = ready_q;
   assign o_valid = (state_q != ST_EMPTY);
   assign o_data  = main_q;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         ST_EMPTY: begin
            if (push) begin
               state_d = ST_ONE;
               main_d  = i_data;
            end
         end
         ST_ONE: begin
            if (push && pop) begin
               main_d = i_data;
            end else if (push) begin
               state_d = ST_TWO;
               skid_d  = i_data;
            end else if (pop) begin
               state_d = ST_EMPTY;
            end
         end
         ST_TWO: begin
            // o_ready is low here, so the only possible event is a pop
            if (pop) begin
               state_d = ST_ONE;
               main_d  = skid_q;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         ready_q <= (state_d != ST_TWO);
      end
   end

`ifdef REG_SLICE_CHK_EN
   logic                  stall_q;
   logic [DATA_WIDTH-1:0] stall_data_q;
   logic                  err_q;
   logic                  err_set;

   // a stalled producer must keep i_valid high and i_data unchanged
   always_comb begin
      err_set = (stall_q && (!i_valid || (i_data != stall_data_q)))
              || (i_valid && $isunknown(i_data));
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         stall_q      <= 1'b0;
         stall_data_q <= '0;
         err_q        <= 1'b0;
      end else begin
         stall_q      <= i_valid & ~ready_q;
         stall_data_q <= i_data;
         err_q        <= err_q | err_set;
      end
   end

`ifndef SYNTHESIS
   always @(posedge i_clk) begin
      if (i_rst_n && err_set && !err_q)
         $error("reg_slice_skid: upstream valid/data changed while stalled");
   end
`endif

   assign o_err = err_q;
`else
   assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_reg_slice_skid.sv
// tb/tb_reg_slice_skid.sv - directed and randomized scoreboard bench for reg_slice_skid
module tb_reg_slice_skid;
   localparam int DW = 32;

   logic          i_clk = 1'b0;
   logic          i_rst_n = 1'b0;
   logic          i_valid = 1'b0;
   logic          o_ready;
   logic [DW-1:0] i_data = '0;
   logic          o_valid;
   logic          i_ready = 1'b0;
   logic [DW-1:0] o_data;
   logic          o_err;

   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] model[$];
   logic          seen_edge;

   reg_slice_skid #(.DATA_WIDTH(DW)) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_data  (i_data),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_data  (o_data),
      .o_err   (o_err)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // the slice may only accept once a clock edge has passed since reset release
   always @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) seen_edge <= 1'b0;
      else          seen_edge <= 1'b1;
   end

   // scoreboard: a FIFO of at most two accepted payloads
   always @(negedge i_clk) begin
      if (!i_rst_n) begin
         chk("rst_valid", {31'b0, o_valid}, '0);
         chk("rst_ready", {31'b0, o_ready}, '0);
         chk("rst_data", o_data, '0);
         model.delete();
      end else begin
         chk("mon_valid", {31'b0, o_valid}, {31'b0, model.size() != 0});
         chk("mon_ready", {31'b0, o_ready}, {31'b0, seen_edge && (model.size() < 2)});
         if (model.size() != 0) chk("mon_data", o_data, model[0]);
         if (o_valid && i_ready && model.size() != 0) void'(model.pop_front());
         if (i_valid && o_ready) model.push_back(i_data);
      end
   end

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_reset();
      i_rst_n = 1'b0;
      i_valid = 1'b0;
      step();
      step();
      i_rst_n = 1'b1;
      step();
   endtask

   initial begin
      logic held;
      int   vp, rp;
      logic exp_err;

      // reset release and idle
      repeat (3) step();
      chk("t1_ready_in_rst", {31'b0, o_ready}, '0);
      chk("t1_valid_in_rst", {31'b0, o_valid}, '0);
      chk("t1_err_in_rst", {31'b0, o_err}, '0);
      i_rst_n = 1'b1;
      #2;
      chk("t1_ready_before_edge", {31'b0, o_ready}, '0);
      step();
      chk("t1_ready_after_edge", {31'b0, o_ready}, 32'd1);
      chk("t1_data_idle", o_data, '0);
      chk("t1_valid_idle", {31'b0, o_valid}, '0);

      // streaming with downstream always ready
      i_ready = 1'b1;
      i_valid = 1'b1; i_data = 32'h1;
      step();
      chk("t2_data1", o_data, 32'h1);
      i_data = 32'h2;
      step();
      chk("t2_data2", o_data, 32'h2);
      chk("t2_ready", {31'b0, o_ready}, 32'd1);
      i_data = 32'h3;
      step();
      chk("t2_data3", o_data, 32'h3);
      chk("t2_ready3", {31'b0, o_ready}, 32'd1);
      i_valid = 1'b0;
      step();
      chk("t2_drained", {31'b0, o_valid}, '0);

      // stall fills both entries
      i_ready = 1'b0;
      i_valid = 1'b1; i_data = 32'hA;
      step();
      i_data = 32'hB;
      step();
      i_valid = 1'b0;
      chk("t3_ready_full", {31'b0, o_ready}, '0);
      chk("t3_data_held", o_data, 32'hA);
      step();
      chk("t3_data_still", o_data, 32'hA);
      chk("t3_valid_full", {31'b0, o_valid}, 32'd1);
      i_ready = 1'b1;
      step();
      chk("t3_data_b", o_data, 32'hB);
      chk("t3_ready_back", {31'b0, o_ready}, 32'd1);
      step();
      chk("t3_empty", {31'b0, o_valid}, '0);

      // randomized traffic; the producer holds while stalled
      vp = 50; rp = 50;
      for (int i = 0; i < 10000; i++) begin
         if (i % 1000 == 0) begin
            vp = $urandom_range(10, 100);
            rp = $urandom_range(10, 100);
         end
         @(negedge i_clk);
         held = i_valid && !o_ready;
         step();
         if (!held) begin
            i_valid = ($urandom_range(0, 99) < vp);
            i_data  = $urandom;
         end
         i_ready = ($urandom_range(0, 99) < rp);
      end

      // protocol violation while full, then reset while full
      do_reset();
      i_ready = 1'b0;
      i_valid = 1'b1; i_data = 32'hA;
      step();
      i_data = 32'hB;
      step();
      i_data = 32'hC;
      chk("t6_ready_full", {31'b0, o_ready}, '0);
      step();
      i_valid = 1'b0;
      step();
`ifdef REG_SLICE_CHK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      chk("t6_err", {31'b0, o_err}, {31'b0, exp_err});
      repeat (3) step();
      chk("t6_err_sticky", {31'b0, o_err}, {31'b0, exp_err});
      chk("t5_data_full", o_data, 32'hA);
      i_rst_n = 1'b0;
      #1;
      chk("t5_valid_async", {31'b0, o_valid}, '0);
      chk("t5_ready_async", {31'b0, o_ready}, '0);
      chk("t5_data_async", o_data, '0);
      chk("t5_err_cleared", {31'b0, o_err}, '0);
      step();
      i_rst_n = 1'b1;
      i_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t5_no_stale", {31'b0, o_valid}, '0);
      end
      chk("t5_ready_after", {31'b0, o_ready}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
